bcd_modcnt: RTL and testbench

- Parametrised modulo-N counter. It holds its value directly as NDIG packed BCD digits, so no decode table is needed.
- Generalises the fixed 0..23 hour counter to any modulus, e.g. 60 for sec/min, 24 for hours, 100 for centiseconds.
- Adds decrement, parallel BCD load, validity checking, a chainable carry-out and a registered wrap pulse.
- Sits in the clock chain: a stage's `cout` drives the `enin` of the next stage.

---
 rtl/bcd_pkg.sv | 37 +++
 rtl/bcd_modcnt_digit.sv | 27 ++
 rtl/bcd_modcnt.sv | 103 ++++++++++
 tb/tb_bcd_modcnt.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the packed-BCD modulo counter.
// Functions are elaboration-safe so they can seed localparams.
package bcd_pkg;

  localparam logic [3:0] DIG_MAX = 4'd9;
  localparam int MAX_DIG = 4;

  // Binary value to packed BCD, digit 0 in [3:0].
  function automatic logic [15:0] to_bcd(
    input int value,
    input int ndig
  );
    logic [15:0] r;
    int t;
    r = '0;
    t = value;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (i < ndig) r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // True when every used digit is a legal BCD digit.
  function automatic logic bcd_valid(
    input logic [15:0] v,
    input int ndig
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (i < ndig && v[4*i+:4] > DIG_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_modcnt_digit.sv
// One BCD digit of the ripple incrementer/decrementer.
// Purely combinational; the top chains NDIG of these.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       ci_up,
  input  logic       ci_dn,
  output logic [3:0] q,
  output logic       co_up,
  output logic       co_dn
);

  assign co_up = ci_up & (d == DIG_MAX);
  assign co_dn = ci_dn & (d == 4'd0);

  // Next digit value for a carry-in, borrow-in, or hold.
  always_comb begin
    q = d;
    unique case (1'b1)
      ci_up: q = (d == DIG_MAX) ? 4'd0 : d + 4'd1;
      ci_dn: q = (d == 4'd0) ? DIG_MAX : d - 4'd1;
      default: q = d;
    endcase
  end

endmodule

// File: rtl/bcd_modcnt.sv
// Modulo-N counter held as packed BCD digits, with
// up/down step, checked parallel load and chain carry.
module bcd_modcnt
  import bcd_pkg::*;
#(
  parameter int NDIG    = 2,
  parameter int MODULUS = 24,
  parameter int START   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enin,
  input  logic              inc,
  input  logic              dec,
  input  logic              ld,
  input  logic [4*NDIG-1:0] ld_val,
  output logic [4*NDIG-1:0] bcd,
  output logic              cout,
  output logic              wrap,
  output logic              err
);

  localparam int W = 4 * NDIG;

  if (NDIG < 1 || NDIG > MAX_DIG ||
      MODULUS < 2 || MODULUS > 10 ** NDIG ||
      START < 0 || START >= MODULUS) begin : g_bad
    $fatal(1, "bcd_modcnt: illegal NDIG/MODULUS/START");
  end

  localparam logic [15:0] MAX16 =
    to_bcd(MODULUS - 1, NDIG);
  localparam logic [15:0] ST16 = to_bcd(START, NDIG);

  localparam logic [W-1:0] MAX_BCD   = MAX16[W-1:0];
  localparam logic [W-1:0] ZERO_BCD  = '0;
  localparam logic [W-1:0] START_BCD = ST16[W-1:0];

  logic          up;
  logic          step_up;
  logic          step_dn;
  logic          wrap_up;
  logic          wrap_dn;
  logic          ld_ok;
  logic [NDIG:0] cu;
  logic [NDIG:0] cd;
  logic [W-1:0]  nxt;

  assign up      = enin | inc;
  assign step_up = up & ~dec;
  assign step_dn = dec & ~up;

  assign cu[0] = step_up;
  assign cd[0] = step_dn;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .d     (bcd[4*i+:4]),
      .ci_up (cu[i]),
      .ci_dn (cd[i]),
      .q     (nxt[4*i+:4]),
      .co_up (cu[i+1]),
      .co_dn (cd[i+1])
    );
  end

  // A full-width ripple overflow can only occur at the
  // top of the range, so it simply reinforces the wrap.
  assign wrap_up = step_up & ((bcd == MAX_BCD) | cu[NDIG]);
  assign wrap_dn = step_dn & ((bcd == ZERO_BCD) | cd[NDIG]);

  // Valid BCD compares in the same order as its value.
  assign ld_ok = bcd_valid(16'(ld_val), NDIG) &&
                 (ld_val <= MAX_BCD);

  assign cout = enin & ~dec & ~ld & ~rst &
                (bcd == MAX_BCD);

  // Counter register with load, wrap override and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd  <= START_BCD;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (ld) begin
        if (ld_ok) bcd <= ld_val;
        else       err <= 1'b1;
      end else if (wrap_up) begin
        bcd  <= ZERO_BCD;
        wrap <= 1'b1;
      end else if (wrap_dn) begin
        bcd  <= MAX_BCD;
        wrap <= 1'b1;
      end else begin
        bcd <= nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_modcnt.sv
// Self-checking bench for bcd_modcnt: table vectors with a
// scoreboard model, plus a full-day sec/min/hour chain.
module tb_bcd_modcnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enin, inc, dec, ld;
  logic [7:0] ld_val;

  logic [7:0] b24, b60, b12;
  logic c24, c60, c12, w24, w60, w12, e24, e60, e12;

  logic       cen;
  logic [7:0] bs, bm, bh;
  logic cs, cm, ch, ws, wm, wh, es, em, eh;

  int total = 0;
  int bad   = 0;

  bcd_modcnt u24 (
    .clk(clk), .rst(rst), .enin(enin), .inc(inc),
    .dec(dec), .ld(ld), .ld_val(ld_val), .bcd(b24),
    .cout(c24), .wrap(w24), .err(e24));

  bcd_modcnt #(.NDIG(2), .MODULUS(60)) u60 (
    .clk(clk), .rst(rst), .enin(enin), .inc(inc),
    .dec(dec), .ld(ld), .ld_val(ld_val), .bcd(b60),
    .cout(c60), .wrap(w60), .err(e60));

  bcd_modcnt #(.NDIG(2), .MODULUS(24), .START(12)) u12 (
    .clk(clk), .rst(rst), .enin(enin), .inc(inc),
    .dec(dec), .ld(ld), .ld_val(ld_val), .bcd(b12),
    .cout(c12), .wrap(w12), .err(e12));

  bcd_modcnt #(.NDIG(2), .MODULUS(60)) u_sec (
    .clk(clk), .rst(rst), .enin(cen), .inc(1'b0),
    .dec(1'b0), .ld(1'b0), .ld_val(8'h00), .bcd(bs),
    .cout(cs), .wrap(ws), .err(es));

  bcd_modcnt #(.NDIG(2), .MODULUS(60)) u_min (
    .clk(clk), .rst(rst), .enin(cs), .inc(1'b0),
    .dec(1'b0), .ld(1'b0), .ld_val(8'h00), .bcd(bm),
    .cout(cm), .wrap(wm), .err(em));

  bcd_modcnt #(.NDIG(2), .MODULUS(24)) u_hr (
    .clk(clk), .rst(rst), .enin(cm), .inc(1'b0),
    .dec(1'b0), .ld(1'b0), .ld_val(8'h00), .bcd(bh),
    .cout(ch), .wrap(wh), .err(eh));

  typedef struct {
    logic       r, l, en, in, de;
    logic [7:0] lv;
    logic       chk;
    logic [7:0] eb;
    logic       ec, ew, ee;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] b;
    logic       w, e;
  } exp_t;

  exp_t sb[$];
  int   mv[3];
  int   mm[3] = '{24, 60, 24};
  int   ms[3] = '{0, 0, 12};

  task automatic chk(string nm, logic [23:0] a,
                     logic [23:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, x);
    end
  endtask

  function automatic logic [7:0] tob(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic vec_t mk(
    logic r, logic l, logic en, logic in, logic de,
    logic [7:0] lv, logic c, logic [7:0] eb,
    logic ec, logic ew, logic ee);
    vec_t t;
    t.r = r; t.l = l; t.en = en; t.in = in; t.de = de;
    t.lv = lv; t.chk = c; t.eb = eb;
    t.ec = ec; t.ew = ew; t.ee = ee;
    return t;
  endfunction

  // Behavioural model in plain binary arithmetic.
  function automatic int mstep(int m, int v, int st,
    vec_t t, output logic w, output logic e);
    int hi, lo;
    logic u;
    w = 1'b0;
    e = 1'b0;
    if (t.r) return st;
    if (t.l) begin
      hi = int'(t.lv[7:4]);
      lo = int'(t.lv[3:0]);
      if (hi <= 9 && lo <= 9 && hi * 10 + lo < m)
        return hi * 10 + lo;
      e = 1'b1;
      return v;
    end
    u = t.en | t.in;
    if (u && !t.de) begin
      if (v == m - 1) begin w = 1'b1; return 0; end
      return v + 1;
    end
    if (t.de && !u) begin
      if (v == 0) begin w = 1'b1; return m - 1; end
      return v - 1;
    end
    return v;
  endfunction

  function automatic logic [9:0] act(int id);
    case (id)
      0: return {b24, w24, e24};
      1: return {b60, w60, e60};
      default: return {b12, w12, e12};
    endcase
  endfunction

  function automatic logic actc(int id);
    case (id)
      0: return c24;
      1: return c60;
      default: return c12;
    endcase
  endfunction

  task automatic apply(vec_t t, string nm);
    logic w, e, c;
    logic [9:0] a;
    exp_t x;
    int nv;
    rst = t.r; ld = t.l; enin = t.en;
    inc = t.in; dec = t.de; ld_val = t.lv;
    #1;
    for (int id = 0; id < 3; id++) begin
      c = t.en & ~t.de & ~t.l & ~t.r &
          (mv[id] == mm[id] - 1);
      chk($sformatf("%s.cout%0d", nm, id),
          24'(actc(id)), 24'(c));
      nv = mstep(mm[id], mv[id], ms[id], t, w, e);
      x.id = id; x.b = tob(nv); x.w = w; x.e = e;
      sb.push_back(x);
      mv[id] = nv;
    end
    if (t.chk) chk({nm, ".tcout"}, 24'(c24), 24'(t.ec));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      a = act(x.id);
      chk($sformatf("%s.bcd%0d", nm, x.id),
          24'(a[9:2]), 24'(x.b));
      chk($sformatf("%s.wrap%0d", nm, x.id),
          24'(a[1]), 24'(x.w));
      chk($sformatf("%s.err%0d", nm, x.id),
          24'(a[0]), 24'(x.e));
    end
    if (t.chk) begin
      chk({nm, ".tbcd"}, 24'(b24), 24'(t.eb));
      chk({nm, ".twrap"}, 24'(w24), 24'(t.ew));
      chk({nm, ".terr"}, 24'(e24), 24'(t.ee));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[24];
    tbl[0]  = mk(1,0,0,0,0,8'h00, 1,8'h00, 0,0,0);
    tbl[1]  = mk(0,0,1,0,0,8'h00, 1,8'h00, 1,1,0);
    tbl[2]  = mk(0,0,0,0,0,8'h00, 1,8'h00, 0,0,0);
    tbl[3]  = mk(0,0,0,0,1,8'h00, 1,8'h23, 0,1,0);
    tbl[4]  = mk(0,0,1,0,1,8'h00, 1,8'h23, 0,0,0);
    tbl[5]  = mk(0,1,0,0,0,8'h17, 1,8'h17, 0,0,0);
    tbl[6]  = mk(0,1,0,0,0,8'h24, 1,8'h17, 0,0,1);
    tbl[7]  = mk(0,0,0,0,0,8'h00, 1,8'h17, 0,0,0);
    tbl[8]  = mk(0,1,0,0,0,8'h1A, 1,8'h17, 0,0,1);
    tbl[9]  = mk(0,1,0,1,0,8'h10, 1,8'h10, 0,0,0);
    tbl[10] = mk(0,0,0,0,1,8'h00, 1,8'h09, 0,0,0);
    tbl[11] = mk(0,0,1,1,0,8'h00, 1,8'h10, 0,0,0);
    tbl[12] = mk(0,0,0,1,0,8'h00, 1,8'h11, 0,0,0);
    tbl[13] = mk(0,1,0,0,0,8'h23, 1,8'h23, 0,0,0);
    tbl[14] = mk(0,0,0,1,0,8'h00, 1,8'h00, 0,1,0);
    tbl[15] = mk(1,1,1,0,0,8'h05, 1,8'h00, 0,0,0);
    tbl[16] = mk(0,1,0,0,0,8'h09, 1,8'h09, 0,0,0);
    tbl[17] = mk(0,0,1,0,0,8'h00, 1,8'h10, 0,0,0);
    tbl[18] = mk(0,1,0,0,0,8'h59, 1,8'h10, 0,0,1);
    tbl[19] = mk(0,0,1,0,0,8'h00, 1,8'h11, 0,0,0);
    tbl[20] = mk(0,1,0,0,0,8'h59, 1,8'h11, 0,0,1);
    tbl[21] = mk(0,0,0,1,0,8'h00, 1,8'h12, 0,0,0);
    tbl[22] = mk(0,1,1,0,0,8'h23, 1,8'h23, 0,0,0);
    tbl[23] = mk(0,1,1,0,0,8'h00, 1,8'h00, 0,0,0);

    rst = 1'b1; enin = 1'b0; inc = 1'b0; dec = 1'b0;
    ld = 1'b0; ld_val = 8'h00; cen = 1'b0;
    mv = ms;
    @(posedge clk);
    #1;

    apply(tbl[0], "reset");
    for (int i = 0; i < 23; i++)
      apply(mk(0,0,1,0,0,8'h00, 0,8'h00, 0,0,0), "count");
    for (int i = 1; i < 24; i++)
      apply(tbl[i], $sformatf("row%0d", i));

    rst = 1'b1; ld = 1'b0; enin = 1'b0;
    inc = 1'b0; dec = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cen = 1'b1;
    repeat (86399) @(posedge clk);
    #1;
    chk("day.hms", {bh, bm, bs}, 24'h235959);
    chk("day.couts", 24'({cs, cm, ch}), 24'h7);
    @(posedge clk);
    #1;
    chk("rollover.hms", {bh, bm, bs}, 24'h000000);
    chk("rollover.wraps", 24'({ws, wm, wh}), 24'h7);
    chk("rollover.errs", 24'({es, em, eh}), 24'h0);
    cen = 1'b0;
    @(posedge clk);
    #1;
    chk("after.wraps", 24'({ws, wm, wh}), 24'h0);
    chk("after.hms", {bh, bm, bs}, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
